// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB/PLRU write sequencer: update FIFO, fetch-read arbitration, flush sweep
// Only this block writes the BTB arrays and PLRU; fetch reads are blocked when a write takes their set.
module btb_update_ctrl #(
    parameter int DEPTH        = 4,
    parameter int INDEX_W      = 7,
    parameter int NUM_SETS     = 128,
    parameter int TAG_W        = 20,
    parameter int TGT_W        = 30,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               BPU__Stall,
    input  logic               Upd_Valid,
    output logic               Upd_Ready,
    input  logic [INDEX_W-1:0] Upd_Index,
    input  logic [TAG_W-1:0]   Upd_Tag,
    input  logic [TGT_W-1:0]   Upd_Target,
    input  logic               Upd_Hit,
    input  logic [1:0]         Upd_Hit_Way,
    input  logic               Fetch_Read_Access,
    input  logic [INDEX_W-1:0] Fetch_Read_Addr,
    input  logic [1:0]         LRU_Set,
    input  logic               Flush_Req,
    output logic [INDEX_W-1:0] BTB_Write_Addr__reg,
    output logic               Write_Access,
    output logic [1:0]         BTB_Wr_Way,
    output logic               BTB_Wr_All_Ways,
    output logic [TAG_W-1:0]   BTB_Wr_Tag,
    output logic [TGT_W-1:0]   BTB_Wr_Target,
    output logic               BTB_Wr_Valid,
    output logic               Read_Block,
    output logic               Flush_Busy,
    output logic               Flush_Done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W:0]   PTR_ONE    = (PTR_W+1)'(1);
    localparam logic [INDEX_W-1:0] SET_ONE  = INDEX_W'(1);
    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(NUM_SETS - 1);
    localparam logic [STV_W-1:0] STV_ONE    = STV_W'(1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [TAG_W-1:0]   tag;
        logic [TGT_W-1:0]   target;
        logic               hit;
        logic [1:0]         hit_way;
    } upd_entry_t;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t             state;
    upd_entry_t         fifo_mem [DEPTH];
    upd_entry_t         head;
    upd_entry_t         push_entry;
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [STV_W-1:0]   starve_cnt;
    logic [INDEX_W-1:0] sweep_cnt;
    logic               flush_pending;

    logic empty;
    logic full;
    logic push;
    logic conflict;
    logic upd_write;
    logic sweep_write;
    logic deferred;
    logic flush_go;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign push_entry = '{index: Upd_Index, tag: Upd_Tag, target: Upd_Target,
                          hit: Upd_Hit, hit_way: Upd_Hit_Way};

    assign Upd_Ready = ~full & (state == IDLE) & ~flush_pending;
    assign push      = Upd_Valid & Upd_Ready;

    // A pending flush suppresses all writes: queued updates are about to be dropped anyway
    // and a restarted sweep must begin cleanly at set 0.
    assign flush_go    = flush_pending & ~BPU__Stall;
    assign conflict    = Fetch_Read_Access & (Fetch_Read_Addr == head.index);
    assign upd_write   = (state == IDLE) & ~empty & ~BPU__Stall & ~flush_pending &
                         (~conflict | (starve_cnt == STARVE_MAX));
    assign deferred    = (state == IDLE) & ~empty & ~BPU__Stall & ~flush_pending &
                         conflict & ~upd_write;
    assign sweep_write = (state == SWEEP) & ~BPU__Stall & ~flush_pending;

    always_comb begin
        BTB_Write_Addr__reg = '0;
        Write_Access        = 1'b0;
        BTB_Wr_Way          = 2'd0;
        BTB_Wr_All_Ways     = 1'b0;
        BTB_Wr_Tag          = '0;
        BTB_Wr_Target       = '0;
        BTB_Wr_Valid        = 1'b0;
        Read_Block          = 1'b0;
        Flush_Busy          = 1'b0;
        if (state == SWEEP) begin
            BTB_Write_Addr__reg = sweep_cnt;
            Write_Access        = sweep_write;
            BTB_Wr_All_Ways     = 1'b1;
            Read_Block          = 1'b1;
            Flush_Busy          = 1'b1;
        end else if (!empty) begin
            BTB_Write_Addr__reg = head.index;
            Write_Access        = upd_write;
            BTB_Wr_Way          = head.hit ? head.hit_way : LRU_Set;
            BTB_Wr_Tag          = head.tag;
            BTB_Wr_Target       = head.target;
            BTB_Wr_Valid        = 1'b1;
            Read_Block          = upd_write & conflict;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            starve_cnt    <= '0;
            sweep_cnt     <= '0;
            flush_pending <= 1'b0;
            Flush_Done    <= 1'b0;
        end else begin
            Flush_Done <= 1'b0;
            if (Flush_Req) begin
                flush_pending <= 1'b1;
            end
            if (flush_go) begin
                // A request arriving in the very cycle we act on the previous one re-arms.
                flush_pending <= Flush_Req;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                starve_cnt    <= '0;
                sweep_cnt     <= '0;
                state         <= SWEEP;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (upd_write) begin
                    rd_ptr     <= rd_ptr + PTR_ONE;
                    starve_cnt <= '0;
                end else if (deferred) begin
                    starve_cnt <= starve_cnt + STV_ONE;
                end
                if (sweep_write) begin
                    if (sweep_cnt == LAST_SET) begin
                        sweep_cnt  <= '0;
                        state      <= IDLE;
                        Flush_Done <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + SET_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - self-checking bench for btb_update_ctrl
// Expected writes are queued at stimulus time and matched by a negedge write monitor.
`timescale 1ns/1ps
module tb_btb_update_ctrl;

    localparam int DEPTH        = 4;
    localparam int INDEX_W      = 7;
    localparam int NUM_SETS     = 128;
    localparam int TAG_W        = 20;
    localparam int TGT_W        = 30;
    localparam int STARVE_LIMIT = 3;

    logic               CLK;
    logic               RST_n;
    logic               BPU__Stall;
    logic               Upd_Valid;
    logic               Upd_Ready;
    logic [INDEX_W-1:0] Upd_Index;
    logic [TAG_W-1:0]   Upd_Tag;
    logic [TGT_W-1:0]   Upd_Target;
    logic               Upd_Hit;
    logic [1:0]         Upd_Hit_Way;
    logic               Fetch_Read_Access;
    logic [INDEX_W-1:0] Fetch_Read_Addr;
    logic [1:0]         LRU_Set;
    logic               Flush_Req;
    logic [INDEX_W-1:0] BTB_Write_Addr__reg;
    logic               Write_Access;
    logic [1:0]         BTB_Wr_Way;
    logic               BTB_Wr_All_Ways;
    logic [TAG_W-1:0]   BTB_Wr_Tag;
    logic [TGT_W-1:0]   BTB_Wr_Target;
    logic               BTB_Wr_Valid;
    logic               Read_Block;
    logic               Flush_Busy;
    logic               Flush_Done;

    btb_update_ctrl #(
        .DEPTH(DEPTH), .INDEX_W(INDEX_W), .NUM_SETS(NUM_SETS),
        .TAG_W(TAG_W), .TGT_W(TGT_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .BPU__Stall(BPU__Stall),
        .Upd_Valid(Upd_Valid), .Upd_Ready(Upd_Ready), .Upd_Index(Upd_Index),
        .Upd_Tag(Upd_Tag), .Upd_Target(Upd_Target), .Upd_Hit(Upd_Hit),
        .Upd_Hit_Way(Upd_Hit_Way), .Fetch_Read_Access(Fetch_Read_Access),
        .Fetch_Read_Addr(Fetch_Read_Addr), .LRU_Set(LRU_Set), .Flush_Req(Flush_Req),
        .BTB_Write_Addr__reg(BTB_Write_Addr__reg), .Write_Access(Write_Access),
        .BTB_Wr_Way(BTB_Wr_Way), .BTB_Wr_All_Ways(BTB_Wr_All_Ways),
        .BTB_Wr_Tag(BTB_Wr_Tag), .BTB_Wr_Target(BTB_Wr_Target),
        .BTB_Wr_Valid(BTB_Wr_Valid), .Read_Block(Read_Block),
        .Flush_Busy(Flush_Busy), .Flush_Done(Flush_Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [INDEX_W-1:0] addr;
        logic [1:0]         way;
        logic               all;
        logic [TAG_W-1:0]   tag;
        logic [TGT_W-1:0]   tgt;
        logic               rb;
    } wr_t;

    typedef struct {
        logic [INDEX_W-1:0] idx;
        logic [TAG_W-1:0]   tag;
        logic [TGT_W-1:0]   tgt;
        logic               hit;
        logic [1:0]         hit_way;
        logic [1:0]         lru;
        logic               rd;
        logic [INDEX_W-1:0] rd_addr;
        logic [1:0]         exp_way;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   done0;
    logic found;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_sweep(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            exp_q.push_back('{addr: INDEX_W'(a), way: 2'd0, all: 1'b1, tag: '0, tgt: '0, rb: 1'b1});
        end
    endtask

    task automatic wait_write(input int addr, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge CLK);
            if (Write_Access && BTB_Write_Addr__reg == INDEX_W'(addr)) seen = 1'b1;
        end
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge CLK);
            if (Flush_Done) seen = 1'b1;
        end
    endtask

    // Write monitor: every strobe must match the next queued expectation.
    always @(negedge CLK) begin
        wr_t e;
        if (RST_n && Write_Access) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%0d all_ways=%0b, required no write",
                         BTB_Write_Addr__reg, BTB_Wr_All_Ways);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(BTB_Write_Addr__reg), 64'(e.addr));
                check("wr_all_ways", 64'(BTB_Wr_All_Ways), 64'(e.all));
                check("wr_valid", 64'(BTB_Wr_Valid), 64'(!e.all));
                check("wr_read_block", 64'(Read_Block), 64'(e.rb));
                if (!e.all) begin
                    check("wr_way", 64'(BTB_Wr_Way), 64'(e.way));
                    check("wr_tag", 64'(BTB_Wr_Tag), 64'(e.tag));
                    check("wr_target", 64'(BTB_Wr_Target), 64'(e.tgt));
                end
            end
        end
    end

    always @(negedge CLK) if (RST_n && Flush_Done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST_n = 1'b1; BPU__Stall = 1'b0; Upd_Valid = 1'b0; Upd_Index = '0; Upd_Tag = '0;
        Upd_Target = '0; Upd_Hit = 1'b0; Upd_Hit_Way = 2'd0; Fetch_Read_Access = 1'b0;
        Fetch_Read_Addr = '0; LRU_Set = 2'd0; Flush_Req = 1'b0;

        vecs[0] = '{idx: 7'd5,   tag: 20'h12345, tgt: 30'h0000_1000, hit: 1'b0, hit_way: 2'd0, lru: 2'd2, rd: 1'b0, rd_addr: 7'd0,  exp_way: 2'd2};
        vecs[1] = '{idx: 7'd9,   tag: 20'hABCDE, tgt: 30'h3FFF_FFFF, hit: 1'b1, hit_way: 2'd3, lru: 2'd0, rd: 1'b0, rd_addr: 7'd0,  exp_way: 2'd3};
        vecs[2] = '{idx: 7'd127, tag: 20'hFFFFF, tgt: 30'h0000_0000, hit: 1'b0, hit_way: 2'd2, lru: 2'd1, rd: 1'b1, rd_addr: 7'd126, exp_way: 2'd1};
        vecs[3] = '{idx: 7'd0,   tag: 20'h00001, tgt: 30'h2AAA_AAAA, hit: 1'b1, hit_way: 2'd1, lru: 2'd3, rd: 1'b0, rd_addr: 7'd0,  exp_way: 2'd1};
        vecs[4] = '{idx: 7'd64,  tag: 20'h55555, tgt: 30'h1555_5555, hit: 1'b1, hit_way: 2'd0, lru: 2'd2, rd: 1'b1, rd_addr: 7'd65, exp_way: 2'd0};
        vecs[5] = '{idx: 7'd33,  tag: 20'h0F0F0, tgt: 30'h0123_4567, hit: 1'b0, hit_way: 2'd3, lru: 2'd3, rd: 1'b1, rd_addr: 7'd1,  exp_way: 2'd3};

        #2 RST_n = 1'b0;
        @(negedge CLK);
        check("rst_ready", 64'(Upd_Ready), 64'd1);
        check("rst_write", 64'(Write_Access), 64'd0);
        check("rst_busy", 64'(Flush_Busy), 64'd0);
        check("rst_done", 64'(Flush_Done), 64'd0);
        check("rst_rblock", 64'(Read_Block), 64'd0);
        check("rst_addr", 64'(BTB_Write_Addr__reg), 64'd0);
        cyc();
        RST_n = 1'b1;

        // Single-update vectors: write lands the cycle after accept, never the same cycle.
        for (int i = 0; i < 6; i++) begin
            Upd_Valid = 1'b1; Upd_Index = vecs[i].idx; Upd_Tag = vecs[i].tag;
            Upd_Target = vecs[i].tgt; Upd_Hit = vecs[i].hit; Upd_Hit_Way = vecs[i].hit_way;
            LRU_Set = vecs[i].lru; Fetch_Read_Access = vecs[i].rd; Fetch_Read_Addr = vecs[i].rd_addr;
            exp_q.push_back('{addr: vecs[i].idx, way: vecs[i].exp_way, all: 1'b0,
                              tag: vecs[i].tag, tgt: vecs[i].tgt, rb: 1'b0});
            @(negedge CLK);
            check("vec_push_ready", 64'(Upd_Ready), 64'd1);
            check("vec_no_bypass", 64'(Write_Access), 64'd0);
            cyc();
            Upd_Valid = 1'b0;
            @(negedge CLK);
            check("vec_write", 64'(Write_Access), 64'd1);
            cyc();
            check("vec_drained", 64'(exp_q.size()), 64'd0);
        end
        Fetch_Read_Access = 1'b0;

        // Fill to full while stalled, then 5 writes on consecutive cycles.
        BPU__Stall = 1'b1;
        LRU_Set = 2'd1;
        for (int i = 0; i < 4; i++) begin
            Upd_Valid = 1'b1; Upd_Index = INDEX_W'(20 + i); Upd_Tag = TAG_W'(32'h100 + i);
            Upd_Target = TGT_W'(i * 3 + 1); Upd_Hit = (i % 2 == 1); Upd_Hit_Way = 2'(i);
            exp_q.push_back('{addr: INDEX_W'(20 + i), way: (i % 2 == 1) ? 2'(i) : 2'd1, all: 1'b0,
                              tag: TAG_W'(32'h100 + i), tgt: TGT_W'(i * 3 + 1), rb: 1'b0});
            @(negedge CLK);
            check("fill_ready", 64'(Upd_Ready), 64'd1);
            check("fill_stall_write", 64'(Write_Access), 64'd0);
            cyc();
        end
        Upd_Index = 7'd24; Upd_Tag = 20'h00105; Upd_Target = 30'h77; Upd_Hit = 1'b0; Upd_Hit_Way = 2'd2;
        @(negedge CLK);
        check("full_ready", 64'(Upd_Ready), 64'd0);
        check("full_stall_write", 64'(Write_Access), 64'd0);
        cyc();
        BPU__Stall = 1'b0;
        exp_q.push_back('{addr: 7'd24, way: 2'd1, all: 1'b0, tag: 20'h00105, tgt: 30'h77, rb: 1'b0});
        @(negedge CLK);
        check("full_pop_no_accept", 64'(Upd_Ready), 64'd1 - 64'd1);
        check("consec_write0", 64'(Write_Access), 64'd1);
        cyc();
        @(negedge CLK);
        check("ready_after_pop", 64'(Upd_Ready), 64'd1);
        check("consec_write1", 64'(Write_Access), 64'd1);
        cyc();
        Upd_Valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            @(negedge CLK);
            check("consec_write", 64'(Write_Access), 64'd1);
            cyc();
        end
        check("fill_drained", 64'(exp_q.size()), 64'd0);

        // Conflicting fetch read every cycle: 3 deferrals, then the write wins; twice.
        Fetch_Read_Access = 1'b1; Fetch_Read_Addr = 7'd9;
        for (int r = 0; r < 2; r++) begin
            Upd_Valid = 1'b1; Upd_Index = 7'd9; Upd_Tag = TAG_W'(32'hBEEF + r);
            Upd_Target = TGT_W'(32'h5000 + r); Upd_Hit = 1'b1; Upd_Hit_Way = 2'd2;
            exp_q.push_back('{addr: 7'd9, way: 2'd2, all: 1'b0, tag: TAG_W'(32'hBEEF + r),
                              tgt: TGT_W'(32'h5000 + r), rb: 1'b1});
            cyc();
            Upd_Valid = 1'b0;
            for (int d = 0; d < STARVE_LIMIT; d++) begin
                @(negedge CLK);
                check("defer_write", 64'(Write_Access), 64'd0);
                check("defer_rblock", 64'(Read_Block), 64'd0);
                cyc();
            end
            @(negedge CLK);
            check("starve_win_write", 64'(Write_Access), 64'd1);
            check("starve_win_rblock", 64'(Read_Block), 64'd1);
            cyc();
        end
        Fetch_Read_Access = 1'b0;
        check("starve_drained", 64'(exp_q.size()), 64'd0);

        // Two queued entries dropped by a flush; full 128-set sweep follows.
        BPU__Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Upd_Valid = 1'b1; Upd_Index = INDEX_W'(30 + i); Upd_Hit = 1'b0;
            cyc();
        end
        Upd_Valid = 1'b0;
        Flush_Req = 1'b1;
        cyc();
        Flush_Req = 1'b0;
        @(negedge CLK);
        check("pending_ready", 64'(Upd_Ready), 64'd0);
        check("pending_stall_write", 64'(Write_Access), 64'd0);
        cyc();
        push_sweep(0, NUM_SETS - 1);
        done0 = done_cnt;
        BPU__Stall = 1'b0;
        @(negedge CLK);
        check("pending_write", 64'(Write_Access), 64'd0);
        cyc();
        @(negedge CLK);
        check("sweep_busy", 64'(Flush_Busy), 64'd1);
        check("sweep_ready", 64'(Upd_Ready), 64'd0);
        wait_done(found);
        check("flush_done_seen", 64'(found), 64'd1);
        check("sweep_drained", 64'(exp_q.size()), 64'd0);
        check("done_busy", 64'(Flush_Busy), 64'd0);
        check("done_ready", 64'(Upd_Ready), 64'd1);
        repeat (3) @(negedge CLK);
        check("done_pulses", 64'(done_cnt - done0), 64'd1);
        check("dropped_no_write", 64'(Write_Access), 64'd0);

        // Sweep with a 5-cycle stall at index 21 and a restart requested while writing 60.
        cyc();
        push_sweep(0, 60);
        push_sweep(0, NUM_SETS - 1);
        done0 = done_cnt;
        Flush_Req = 1'b1;
        cyc();
        Flush_Req = 1'b0;
        wait_write(20, found);
        check("saw_idx20", 64'(found), 64'd1);
        cyc();
        BPU__Stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge CLK);
            check("stall_write", 64'(Write_Access), 64'd0);
            check("stall_hold_addr", 64'(BTB_Write_Addr__reg), 64'd21);
            check("stall_rblock", 64'(Read_Block), 64'd1);
            check("stall_busy", 64'(Flush_Busy), 64'd1);
            cyc();
        end
        BPU__Stall = 1'b0;
        wait_write(59, found);
        check("saw_idx59", 64'(found), 64'd1);
        cyc();
        Flush_Req = 1'b1;
        cyc();
        Flush_Req = 1'b0;
        @(negedge CLK);
        check("restart_pending_write", 64'(Write_Access), 64'd0);
        check("restart_busy", 64'(Flush_Busy), 64'd1);
        wait_done(found);
        check("restart_done_seen", 64'(found), 64'd1);
        check("restart_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge CLK);
        check("restart_done_pulses", 64'(done_cnt - done0), 64'd1);

        // Asynchronous reset in the middle of a sweep.
        cyc();
        push_sweep(0, NUM_SETS - 1);
        done0 = done_cnt;
        Flush_Req = 1'b1;
        cyc();
        Flush_Req = 1'b0;
        repeat (30) @(negedge CLK);
        #2;
        RST_n = 1'b0;
        #1;
        check("arst_write", 64'(Write_Access), 64'd0);
        check("arst_ready", 64'(Upd_Ready), 64'd1);
        check("arst_busy", 64'(Flush_Busy), 64'd0);
        check("arst_rblock", 64'(Read_Block), 64'd0);
        check("arst_all_ways", 64'(BTB_Wr_All_Ways), 64'd0);
        check("arst_addr", 64'(BTB_Write_Addr__reg), 64'd0);
        exp_q.delete();
        cyc();
        RST_n = 1'b1;
        repeat (4) @(negedge CLK);
        check("post_rst_busy", 64'(Flush_Busy), 64'd0);
        check("post_rst_done", 64'(done_cnt - done0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
